vbus_ram_responder: RTL and testbench

Bus-slave (responder) end of the 68010 asynchronous bus: decodes its own address window, inserts programmable wait states, honours WAIT_b stretching, and returns DTACK_b. Backs a 2^ADDR_W x 16 on-chip RAM with byte-lane writes. Sits on the CPU side of the video/working-RAM decode. It is the DTACK source for its window, so no separate counter-based DTACK is needed there.

---
 rtl/vbus_ram_responder_if.sv | 26 ++
 rtl/vbus_ram_responder.sv | 124 ++++++++++++
 tb/tb_vbus_ram_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vbus_ram_responder_if.sv
// Bus-side signal bundle for the 68010-style asynchronous bus responder.
// The master modport is the CPU/bench side; the slave modport is the RAM responder.
interface vbus_ram_responder_if;
   logic [22:0] A;
   logic [15:0] D_in;
   logic [15:0] D_out;
   logic        D_oe;
   logic        R_W_b;
   logic        AS_b;
   logic        UDS_b;
   logic        LDS_b;
   logic        WAIT_b;
   logic        DTACK_b;
   logic        SEL_b;
   logic        BUSY;

   modport master (
      output A, D_in, R_W_b, AS_b, UDS_b, LDS_b, WAIT_b,
      input  D_out, D_oe, DTACK_b, SEL_b, BUSY
   );

   modport slave (
      input  A, D_in, R_W_b, AS_b, UDS_b, LDS_b, WAIT_b,
      output D_out, D_oe, DTACK_b, SEL_b, BUSY
   );
endinterface

// File: rtl/vbus_ram_responder.sv
// Bus responder for one address window: programmable wait states, WAIT_b
// stretching, DTACK_b generation and a 2^ADDR_W x 16 byte-writable RAM.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no cycle to this window; waiting for AS_b low with a hit
// ST_WAIT    | cycle accepted; counting wait states, WAIT_b freezes count
// ST_ACK     | DTACK_b low (and D_oe for reads) until AS_b is seen high
// ST_RELEASE | one cycle with DTACK_b high before a new cycle can start
module vbus_ram_responder #(
   parameter int          ADDR_W      = 11,
   parameter logic [22:0] BASE_ADDR   = 23'h000000,
   parameter int          WAIT_STATES = 2
) (
   input logic               MCKR,
   input logic               SYSRES,
   vbus_ram_responder_if.slave bus
);

   generate
      if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
         $error("vbus_ram_responder: WAIT_STATES must be in 0..15");
      end
   endgenerate

   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_RELEASE
   } state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       d_out_q;
   logic              d_oe_q;
   logic              dtack_b_q;
   logic              sel_b_q;
   logic              hit;
   logic              ack_go;
   logic              wr_en;

   logic [15:0] mem [2**ADDR_W];

   assign hit = (bus.A[22:ADDR_W] == BASE_ADDR[22:ADDR_W]);

   // The WAIT->ACK transition: strobe still low, no external wait, count done.
   // Holding wr_en off during SYSRES drops a write caught by reset.
   assign ack_go = (state == ST_WAIT) && !bus.AS_b && bus.WAIT_b && (cnt == 4'd0);
   assign wr_en  = ack_go && !bus.R_W_b && !SYSRES;

   assign bus.D_out   = d_out_q;
   assign bus.D_oe    = d_oe_q;
   assign bus.DTACK_b = dtack_b_q;
   assign bus.SEL_b   = sel_b_q;
   assign bus.BUSY    = (state != ST_IDLE);

   // Byte-lane RAM write, exactly once per accepted write cycle; contents survive reset.
   always_ff @(posedge MCKR) begin
      if (wr_en) begin
         if (!bus.UDS_b) mem[addr][15:8] <= bus.D_in[15:8];
         if (!bus.LDS_b) mem[addr][7:0]  <= bus.D_in[7:0];
      end
   end

   // Bus cycle sequencer with registered handshake outputs.
   always_ff @(posedge MCKR or posedge SYSRES) begin
      if (SYSRES) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         addr      <= '0;
         d_out_q   <= 16'h0000;
         d_oe_q    <= 1'b0;
         dtack_b_q <= 1'b1;
         sel_b_q   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!bus.AS_b && hit) begin
                  addr    <= bus.A[ADDR_W-1:0];
                  cnt     <= WS_INIT;
                  sel_b_q <= 1'b0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.AS_b) begin
                  sel_b_q <= 1'b1;
                  state   <= ST_IDLE;
               end else if (!bus.WAIT_b) begin
                  cnt <= cnt;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  dtack_b_q <= 1'b0;
                  state     <= ST_ACK;
                  if (bus.R_W_b) begin
                     d_out_q <= mem[addr];
                     d_oe_q  <= 1'b1;
                  end
               end
            end
            ST_ACK: begin
               if (bus.AS_b) begin
                  dtack_b_q <= 1'b1;
                  d_oe_q    <= 1'b0;
                  sel_b_q   <= 1'b1;
                  state     <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vbus_ram_responder.sv
// Self-checking bench for vbus_ram_responder: directed bus cycles followed by
// random reads/writes checked against a word-array model of the RAM window.
module tb_vbus_ram_responder;

   localparam int          ADDR_W = 11;
   localparam logic [22:0] BASE   = 23'h200000;
   localparam int          WS     = 2;

   logic MCKR = 1'b0;
   logic SYSRES;
   int   n_pass  = 0;
   int   n_total = 0;

   logic [15:0] model [16];

   vbus_ram_responder_if bus ();

   vbus_ram_responder #(
      .ADDR_W      (ADDR_W),
      .BASE_ADDR   (BASE),
      .WAIT_STATES (WS)
   ) dut (
      .MCKR   (MCKR),
      .SYSRES (SYSRES),
      .bus    (bus)
   );

   always #5 MCKR = ~MCKR;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge MCKR);
      #1;
   endtask

   task automatic start(input logic [22:0] a, input logic rw, input logic [15:0] d,
                        input logic uds, input logic lds);
      bus.A     = a;
      bus.R_W_b = rw;
      bus.D_in  = d;
      bus.UDS_b = uds;
      bus.LDS_b = lds;
      bus.AS_b  = 1'b0;
   endtask

   // Counts edges from now until DTACK_b is seen low; WAIT_b is low before edges at..at+len-1.
   task automatic wait_ack(input string tag, input int exp_edges, input int at, input int len);
      int k;
      k = 0;
      while (k < 40) begin
         k++;
         bus.WAIT_b = !(k >= at && k < at + len);
         tick();
         if (bus.DTACK_b === 1'b0) break;
      end
      bus.WAIT_b = 1'b1;
      check({tag, "_latency"}, k, exp_edges);
   endtask

   task automatic release_check(input string tag);
      bus.AS_b = 1'b1;
      tick();
      check({tag, "_rel_dtack"}, bus.DTACK_b, 1'b1);
      check({tag, "_rel_oe"}, bus.D_oe, 1'b0);
      check({tag, "_rel_sel"}, bus.SEL_b, 1'b1);
      tick();
      check({tag, "_idle_busy"}, bus.BUSY, 1'b0);
   endtask

   // Full hit cycle; the model is updated for writes and consulted for reads.
   task automatic bus_cycle(input string tag, input logic [3:0] off, input logic rw,
                            input logic [15:0] d, input logic uds, input logic lds,
                            input int at, input int len);
      start(BASE | 23'(off), rw, d, uds, lds);
      tick();
      check({tag, "_sel"}, bus.SEL_b, 1'b0);
      wait_ack(tag, WS + 1 + len, at, len);
      if (rw) begin
         check({tag, "_rdata"}, bus.D_out, model[off]);
         check({tag, "_oe"}, bus.D_oe, 1'b1);
      end else begin
         check({tag, "_wr_oe"}, bus.D_oe, 1'b0);
         if (!uds) model[off][15:8] = d[15:8];
         if (!lds) model[off][7:0]  = d[7:0];
      end
      release_check(tag);
   endtask

   initial begin
      bus.A      = '0;
      bus.D_in   = '0;
      bus.R_W_b  = 1'b1;
      bus.AS_b   = 1'b1;
      bus.UDS_b  = 1'b1;
      bus.LDS_b  = 1'b1;
      bus.WAIT_b = 1'b1;
      SYSRES     = 1'b1;
      #12;
      check("rst_dtack", bus.DTACK_b, 1'b1);
      check("rst_oe", bus.D_oe, 1'b0);
      check("rst_dout", bus.D_out, 16'h0000);
      check("rst_sel", bus.SEL_b, 1'b1);
      check("rst_busy", bus.BUSY, 1'b0);
      tick();
      SYSRES = 1'b0;
      tick();

      // Write/read back and byte lanes at word 5.
      bus_cycle("wr_beef", 4'd5, 1'b0, 16'hBEEF, 1'b0, 1'b0, 0, 0);
      bus_cycle("rd_beef", 4'd5, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 0);
      check("model_beef", model[5], 16'hBEEF);
      bus_cycle("wr_lo", 4'd5, 1'b0, 16'h1234, 1'b1, 1'b0, 0, 0);
      bus_cycle("rd_be34", 4'd5, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 0);
      check("model_be34", model[5], 16'hBE34);
      bus_cycle("wr_none", 4'd5, 1'b0, 16'hFFFF, 1'b1, 1'b1, 0, 0);
      bus_cycle("rd_none", 4'd5, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 0);

      // WAIT_b low for three edges starting at N+1: acknowledge at N+6.
      bus_cycle("wait_wr", 4'd7, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1, 3);
      bus_cycle("wait_rd", 4'd7, 1'b1, 16'h0000, 1'b0, 1'b0, 1, 3);

      // Abort during WAIT with cnt=1: no acknowledge, no write.
      start(BASE | 23'd5, 1'b0, 16'hDEAD, 1'b0, 1'b0);
      tick();
      check("abort_busy_n", bus.BUSY, 1'b1);
      tick();
      check("abort_noack", bus.DTACK_b, 1'b1);
      bus.AS_b = 1'b1;
      tick();
      check("abort_busy", bus.BUSY, 1'b0);
      check("abort_dtack", bus.DTACK_b, 1'b1);
      check("abort_sel", bus.SEL_b, 1'b1);
      bus_cycle("abort_rd", 4'd5, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 0);

      // Out-of-window cycle is never acknowledged.
      start(23'h100005, 1'b1, 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("miss_dtack", bus.DTACK_b, 1'b1);
         check("miss_oe", bus.D_oe, 1'b0);
         check("miss_sel", bus.SEL_b, 1'b1);
      end
      bus.AS_b = 1'b1;
      tick();

      // Reset in ACK clears outputs without a clock edge.
      start(BASE | 23'd5, 1'b1, 16'h0000, 1'b0, 1'b0);
      tick();
      wait_ack("rst_ack", WS + 1, 0, 0);
      check("rst_ack_oe_pre", bus.D_oe, 1'b1);
      #2;
      SYSRES = 1'b1;
      #1;
      check("rst_ack_dtack", bus.DTACK_b, 1'b1);
      check("rst_ack_oe", bus.D_oe, 1'b0);
      check("rst_ack_dout", bus.D_out, 16'h0000);
      check("rst_ack_busy", bus.BUSY, 1'b0);
      bus.AS_b = 1'b1;
      tick();
      SYSRES = 1'b0;
      tick();

      // Back-to-back: AS_b low again right after it is seen high.
      start(BASE | 23'd7, 1'b1, 16'h0000, 1'b0, 1'b0);
      tick();
      wait_ack("b2b_first", WS + 1, 0, 0);
      bus.AS_b = 1'b1;
      tick();
      check("b2b_gap_dtack", bus.DTACK_b, 1'b1);
      bus.AS_b = 1'b0;
      wait_ack("b2b_second", WS + 3, 0, 0);
      check("b2b_rdata", bus.D_out, model[7]);
      release_check("b2b");

      // Random traffic over words 0..15 after seeding them with full writes.
      for (int i = 0; i < 16; i++)
         bus_cycle("seed", 4'(i), 1'b0, 16'($urandom), 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         logic [3:0] off;
         logic       rw;
         int         len;
         int         at;
         off = 4'($urandom_range(15, 0));
         rw  = 1'($urandom_range(1, 0));
         len = $urandom_range(3, 0);
         at  = $urandom_range(WS + 1, 1);
         bus_cycle("rand", off, rw, 16'($urandom), 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)), at, len);
      end
      for (int i = 0; i < 16; i++)
         bus_cycle("final_rd", 4'(i), 1'b1, 16'h0000, 1'b0, 1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
